// File: rtl/bcd_digit_collector_if.sv
// Handshake bundle between a digit source / number consumer and the BCD digit collector.
interface bcd_digit_collector_if #(
  parameter int DIGITS = 4
) ();
  localparam int CNT_W = $clog2(DIGITS + 1);

  logic                  clear;
  logic [3:0]            digit_in;
  logic                  digit_valid;
  logic                  digit_ready;
  logic [4*DIGITS-1:0]   number;
  logic                  number_valid;
  logic                  number_ack;
  logic                  digit_error;
  logic [CNT_W-1:0]      count;

  modport master (
    output clear, digit_in, digit_valid, number_ack,
    input  digit_ready, number, number_valid, digit_error, count
  );

  modport slave (
    input  clear, digit_in, digit_valid, number_ack,
    output digit_ready, number, number_valid, digit_error, count
  );
endinterface

// File: rtl/bcd_digit_collector.sv
// Collects DIGITS BCD digits MSD-first and presents the assembled number with a
// valid/ack handshake; non-BCD codes are consumed, dropped and flagged.
module bcd_digit_collector #(
  parameter int DIGITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  bcd_digit_collector_if.slave bus
);
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int NUM_W = 4 * DIGITS;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

  state_e             state_q,  state_d;
  logic [NUM_W-1:0]   number_q, number_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               valid_q,  valid_d;
  logic               error_q,  error_d;

  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= 4'd9);
  endfunction

  // Next-state and output decode; clear outranks any digit or ack activity.
  always_comb begin
    state_d  = state_q;
    number_d = number_q;
    count_d  = count_q;
    valid_d  = valid_q;
    error_d  = error_q;
    if (bus.clear) begin
      state_d  = ST_COLLECT;
      number_d = {NUM_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      valid_d  = 1'b0;
      error_d  = 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (bus.digit_valid) begin
            if (is_bcd(bus.digit_in)) begin
              number_d = {number_q[NUM_W-5:0], bus.digit_in};
              count_d  = count_q + CNT_W'(1);
              if (count_q == CNT_W'(DIGITS - 1)) begin
                state_d = ST_FULL;
                valid_d = 1'b1;
              end else begin
                state_d = ST_COLLECT;
              end
            end else begin
              error_d = 1'b1;
            end
          end else begin
            state_d = ST_COLLECT;
          end
        end
        ST_FULL: begin
          if (bus.number_ack) begin
            state_d  = ST_COLLECT;
            number_d = {NUM_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
            valid_d  = 1'b0;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d  = ST_COLLECT;
          number_d = {NUM_W{1'b0}};
          count_d  = {CNT_W{1'b0}};
          valid_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_COLLECT;
      number_q <= {NUM_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      number_q <= number_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  // Ready comes from the state register only, never from digit_valid.
  assign bus.digit_ready  = (state_q == ST_COLLECT);
  assign bus.number       = number_q;
  assign bus.count        = count_q;
  assign bus.number_valid = valid_q;
  assign bus.digit_error  = error_q;
endmodule

// File: tb/tb_bcd_digit_collector.sv
// Randomised and directed bench for bcd_digit_collector against a queue-based model.
module tb_bcd_digit_collector;
  localparam int DIGITS = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;
  bit   chk_en   = 1'b0;

  bcd_digit_collector_if #(.DIGITS(DIGITS)) bus ();

  bcd_digit_collector #(.DIGITS(DIGITS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the list of digits accepted so far, plus FULL and sticky-error flags.
  int m_q[$];
  bit m_full = 1'b0;
  bit m_err  = 1'b0;

  function automatic logic [15:0] m_number();
    logic [15:0] n;
    n = 16'h0000;
    foreach (m_q[i]) n = n * 16'd16 + 16'(m_q[i]);
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst || bus.clear) begin
      m_q.delete();
      m_full = 1'b0;
      m_err  = 1'b0;
    end else if (!m_full) begin
      if (bus.digit_valid) begin
        if (bus.digit_in <= 4'd9) begin
          m_q.push_back(int'(bus.digit_in));
          if (m_q.size() == DIGITS) m_full = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (bus.number_ack) begin
      m_q.delete();
      m_full = 1'b0;
    end
    cyc_n++;
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic [21:0] got, exp;
    if (chk_en) begin
      got = {bus.digit_ready, bus.number_valid, bus.digit_error, bus.count, bus.number};
      exp = {!m_full, m_full, m_err, 3'(m_q.size()), m_number()};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL cycle_cmp cyc=%0d got=%h exp=%h (rdy,vld,err,cnt,num)", cyc_n, got, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then return at the following falling edge.
  task automatic cyc(input logic r, input logic c, input logic v, input logic [3:0] d,
                     input logic a);
    rst             = r;
    bus.clear       = c;
    bus.digit_valid = v;
    bus.digit_in    = d;
    bus.number_ack  = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] d);
    cyc(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.clear       = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.number_ack  = 1'b0;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk_en = 1'b1;
    chk("reset_rdy", 32'(bus.digit_ready), 32'd1);
    chk("reset_num", 32'(bus.number), 32'd0);

    // 1,2,1,0 then 1,2,3,4
    digit(4'd1); digit(4'd2); digit(4'd1); digit(4'd0);
    chk("num_1210", 32'(bus.number), 32'h1210);
    chk("model_1210", 32'(m_number()), 32'h1210);
    chk("vld_1210", 32'(bus.number_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("rdy_after_ack", 32'(bus.digit_ready), 32'd1);
    digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
    chk("num_1234", 32'(bus.number), 32'h1234);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

    // non-BCD digit dropped
    digit(4'd9); digit(4'hB);
    chk("err_after_b", 32'(bus.digit_error), 32'd1);
    chk("cnt_after_b", 32'(bus.count), 32'd1);
    digit(4'd9); digit(4'd0); digit(4'd9);
    chk("num_9909", 32'(bus.number), 32'h9909);
    chk("model_9909", 32'(m_number()), 32'h9909);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

    // hold FULL with no ack while source keeps offering 5
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    digit(4'd0); digit(4'd0); digit(4'd0); digit(4'd0);
    for (int i = 0; i < 10; i++) digit(4'd5);
    chk("hold_num", 32'(bus.number), 32'h0000);
    chk("hold_cnt", 32'(bus.count), 32'd4);
    chk("hold_rdy", 32'(bus.digit_ready), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    chk("ack_cnt", 32'(bus.count), 32'd0);
    digit(4'd5);
    chk("after_ack_num", 32'(bus.number), 32'h0005);

    // clear with a simultaneous digit
    cyc(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    digit(4'd3); digit(4'd4);
    cyc(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
    chk("clr_cnt", 32'(bus.count), 32'd0);
    digit(4'd7); digit(4'd7); digit(4'd0); digit(4'd0);
    chk("num_7700", 32'(bus.number), 32'h7700);
    chk("model_7700", 32'(m_number()), 32'h7700);

    // reset while FULL, then ack while collecting
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    digit(4'd5); digit(4'd5); digit(4'd5); digit(4'd5);
    chk("num_5555", 32'(bus.number), 32'h5555);
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    chk("rst_full_vld", 32'(bus.number_valid), 32'd0);
    digit(4'd3);
    cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    chk("ack_collect_num", 32'(bus.number), 32'h0003);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      d = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) < 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_digit_collector.md
# bcd_digit_collector

Serial-to-parallel front end for the 4-digit BCD divisibility-by-11 checker. It accepts one BCD digit per handshake from a keypad/switch-entry source, rejects non-BCD codes, and assembles DIGITS digits most-significant first. It then presents the complete number, held stable, with a valid/ack handshake. Output nibbles map directly onto the checker's a (most significant) through d (least significant) digit inputs.

## Interface

- DIGITS, 4, number of BCD digits per assembled number; the checker requires 4.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- clear  input  1  synchronous abort: discards the partial or complete number and clears the error flag
- digitIn  input  4  BCD digit offered by the source
- digitValid  input  1  digitIn is valid this cycle
- digitReady  output  1  the block accepts a digit this cycle
- number  output  4*DIGITS  assembled number; [4*DIGITS-1:4*DIGITS-4] is the first digit entered (a), [3:0] is the last digit entered (d)
- numberValid  output  1  number is complete and stable
- numberAck  input  1  consumer has taken number
- digitError  output  1  sticky flag: a non-BCD digit (>9) was offered and dropped
- count  output  clog2(DIGITS+1)  digits accepted so far in the current number

## Operation

- Two states: COLLECT and FULL. The reset state is COLLECT.
- Reset values: number=0, count=0, numberValid=0, digitError=0, state=COLLECT, so digitReady=1.
- digitReady = (state==COLLECT). It is decoded from the registered state only and never depends on digitValid.
- COLLECT, when digitValid && digitReady && digitIn<=9:
  - number <= {number[4*DIGITS-5:0], digitIn}
  - count <= count+1
  - If count==DIGITS-1, move to FULL and set numberValid=1.
- COLLECT, when digitValid && digitIn>9:
  - The digit is consumed (handshake completes) but discarded.
  - number, count and state are unchanged.
  - digitError <= 1. The flag is sticky until clear or reset.
- FULL: number and count (=DIGITS) are held, and numberValid=1. Source digits are not accepted because digitReady=0.
- FULL, when numberAck=1: move to COLLECT, numberValid <= 0, count <= 0, number <= 0. digitError is unaffected.
- numberAck while in COLLECT is ignored.
- Priority: reset > clear > numberAck/digit handling.
  - clear forces state=COLLECT, number=0, count=0, numberValid=0, digitError=0.
  - A digit presented in the same cycle as clear is dropped; the handshake is still considered complete if digitReady was 1.
- Reset or clear in FULL discards the held number without an ack.
- No arithmetic beyond shift and count. digitIn codes 10–15 never enter number, so number is always valid BCD.

## Timing

- All outputs are registered except digitReady. digitReady is decoded from the state register, which adds no combinational path from the inputs.
- Digit acceptance occurs on the rising edge where digitValid && digitReady. number reflects the new digit in the following cycle.
- numberValid rises in the cycle after the edge that accepts digit DIGITS, with no extra latency. number is valid in that same cycle.
- Ack completes on the edge where numberValid && numberAck. digitReady is 1 in the next cycle.
- Minimum period per number: DIGITS+1 cycles (DIGITS digit cycles plus one FULL cycle with an immediate ack).
- digitValid asserted in the same cycle as numberAck while in FULL is not accepted. The source must hold its digit, and it is taken in the next cycle.
- The consumer may delay numberAck indefinitely. number must not change while numberValid=1.

## Test plan

- Reset, then digits 1,2,1,0 on consecutive cycles -> number=16'h1210 and numberValid=1 one cycle after the 4th edge; a connected checker gives isDivider=1. Then 1,2,3,4 -> 16'h1234, isDivider=0.
- Digits 9,0xB,9,0,9 -> 0xB dropped, digitError=1 from the next cycle, count unchanged across the 0xB cycle; final number=16'h9909, numberValid=1.
- Complete 16'h0000, hold numberAck=0 for 10 cycles while offering digit 5 every cycle -> digitReady=0, number stable at 0000, count=4; ack -> COLLECT next cycle, and the digit 5 is accepted then.
- Accept 3,4, then assert clear together with digitValid and digit 7 -> count=0, number=0, digitError=0; the next four digits 7,7,0,0 give 16'h7700.
- Assert reset while in FULL with 16'h5555 -> next cycle all outputs at reset values, digitReady=1. Assert numberAck in COLLECT -> no state change.
